block_nest_checker: RTL

BLOCK_NEST_CHECKER -- requirements
Module: block_nest_checker

---
 rtl/block_nest_checker.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/block_nest_checker.sv
// rtl/block_nest_checker.sv - begin/end keyword nesting checker over an ASCII byte stream
//
// Purpose: tokenizes a space-separated ASCII stream, tracks begin/end nesting
//          depth (provisionally while a word is still open) and flags
//          unbalanced streams.
// Ports:
//   clk        - sole clock, rising edge
//   reset      - asynchronous active-high reset
//   in_valid   - qualifies in; a byte is consumed only when high
//   in[7:0]    - ASCII character
//   result     - stream so far is balanced and error-free
//   depth      - current provisional nesting depth
//   underflow  - sticky: an "end" closed with nothing open
//   overflow   - sticky: a "begin" closed at MAX_DEPTH
module block_nest_checker #(
  parameter int DEPTH_W   = 8,
  parameter int MAX_DEPTH = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               underflow,
  output logic               overflow
);

  typedef enum logic [3:0] {
    S_SEP, S_B, S_BE, S_BEG, S_BEGI, S_BEGIN, S_E, S_EN, S_END, S_OTHER
  } state_t;

  localparam logic [DEPTH_W-1:0] L_MAX  = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] L_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] L_ZERO = '0;

  state_t             r_state;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_beg_pend;
  logic               r_end_pend;
  logic               r_underflow;
  logic               r_overflow;
  logic               r_result;

  state_t             w_state_nxt;
  logic [DEPTH_W-1:0] w_depth_nxt;
  logic               w_beg_nxt;
  logic               w_end_nxt;
  logic               w_uf_nxt;
  logic               w_of_nxt;
  logic               w_result_nxt;
  logic               w_space;
  logic               w_err;

  // Case-insensitive match against a lowercase keyword letter.
  function automatic logic is_ch(input logic [7:0] c, input logic [7:0] lower);
    return (c == lower) || (c == (lower - 8'h20));
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_depth_nxt = r_depth;
    w_beg_nxt   = r_beg_pend;
    w_end_nxt   = r_end_pend;
    w_uf_nxt    = r_underflow;
    w_of_nxt    = r_overflow;
    w_space     = (in == 8'h20);
    // Once an error is latched the depth bookkeeping freezes; only the
    // tokenizer keeps running.
    w_err       = r_underflow | r_overflow;

    if (in_valid) begin
      case (r_state)
        S_SEP: begin
          if (w_space)               w_state_nxt = S_SEP;
          else if (is_ch(in, "b"))   w_state_nxt = S_B;
          else if (is_ch(in, "e"))   w_state_nxt = S_E;
          else                       w_state_nxt = S_OTHER;
        end
        S_B: begin
          if (is_ch(in, "e"))        w_state_nxt = S_BE;
          else if (w_space)          w_state_nxt = S_SEP;
          else                       w_state_nxt = S_OTHER;
        end
        S_BE: begin
          if (is_ch(in, "g"))        w_state_nxt = S_BEG;
          else if (w_space)          w_state_nxt = S_SEP;
          else                       w_state_nxt = S_OTHER;
        end
        S_BEG: begin
          if (is_ch(in, "i"))        w_state_nxt = S_BEGI;
          else if (w_space)          w_state_nxt = S_SEP;
          else                       w_state_nxt = S_OTHER;
        end
        S_BEGI: begin
          if (is_ch(in, "n")) begin
            w_state_nxt = S_BEGIN;
            if (!w_err) begin
              if (r_depth == L_MAX) w_beg_nxt   = 1'b1;
              else                  w_depth_nxt = r_depth + L_ONE;
            end
          end else if (w_space)      w_state_nxt = S_SEP;
          else                       w_state_nxt = S_OTHER;
        end
        S_E: begin
          if (is_ch(in, "n"))        w_state_nxt = S_EN;
          else if (w_space)          w_state_nxt = S_SEP;
          else                       w_state_nxt = S_OTHER;
        end
        S_EN: begin
          if (is_ch(in, "d")) begin
            w_state_nxt = S_END;
            if (!w_err) begin
              if (r_depth == L_ZERO) w_end_nxt   = 1'b1;
              else                   w_depth_nxt = r_depth - L_ONE;
            end
          end else if (w_space)      w_state_nxt = S_SEP;
          else                       w_state_nxt = S_OTHER;
        end
        S_BEGIN: begin
          if (w_space) begin
            // Word committed: a pending begin becomes a real overflow.
            w_state_nxt = S_SEP;
            if (!w_err) begin
              if (r_beg_pend) w_of_nxt = 1'b1;
              w_beg_nxt = 1'b0;
              w_end_nxt = 1'b0;
            end
          end else begin
            // Word turned out not to be "begin": undo the provisional effect.
            w_state_nxt = S_OTHER;
            if (!w_err) begin
              if (r_beg_pend) w_beg_nxt   = 1'b0;
              else            w_depth_nxt = r_depth - L_ONE;
            end
          end
        end
        S_END: begin
          if (w_space) begin
            w_state_nxt = S_SEP;
            if (!w_err) begin
              if (r_end_pend) w_uf_nxt = 1'b1;
              w_beg_nxt = 1'b0;
              w_end_nxt = 1'b0;
            end
          end else begin
            w_state_nxt = S_OTHER;
            if (!w_err) begin
              if (r_end_pend) w_end_nxt   = 1'b0;
              else            w_depth_nxt = r_depth + L_ONE;
            end
          end
        end
        S_OTHER: begin
          if (w_space)               w_state_nxt = S_SEP;
          else                       w_state_nxt = S_OTHER;
        end
        default:                     w_state_nxt = S_SEP;
      endcase
    end

    w_result_nxt = (w_depth_nxt == L_ZERO) && !w_beg_nxt && !w_end_nxt &&
                   !w_uf_nxt && !w_of_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_SEP;
      r_depth     <= '0;
      r_beg_pend  <= 1'b0;
      r_end_pend  <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
      r_result    <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_depth     <= w_depth_nxt;
      r_beg_pend  <= w_beg_nxt;
      r_end_pend  <= w_end_nxt;
      r_underflow <= w_uf_nxt;
      r_overflow  <= w_of_nxt;
      r_result    <= w_result_nxt;
    end
  end

  assign result    = r_result;
  assign depth     = r_depth;
  assign underflow = r_underflow;
  assign overflow  = r_overflow;

endmodule
